calc_arbiter: RTL and testbench
===============================

CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter DW, default 4: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before abort; range 1..255.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 req0/req1  in  1  requester 0/1 request; held high until its ack.
REQ-006 op0/op1  in  2  opcode per requester (11 ADD, 10 SUB, 01 AND, 00 XOR).
REQ-007 a0/b0, a1/b1  in  DW  operands per requester.
REQ-008 gnt0/gnt1  out  1  requester owns calculator; one-hot or zero.
REQ-009 ack0/ack1  out  1  one-cycle completion pulse to owning requester.
REQ-010 result  out  DW  result, valid only while an ack is high.
REQ-011 err  out  1  high with ack when the transaction timed out.
REQ-012 calc_go  out  1  one-cycle start pulse to calculator control unit.
REQ-013 calc_op  out  2  opcode forwarded to calculator.
REQ-014 calc_a/calc_b  out  DW  operands forwarded to calculator.
REQ-015 calc_done  in  1  calculator completion.
REQ-016 calc_result  in  DW  calculator output, valid with calc_done.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: any req high -> ISSUE next edge; winner's op/a/b latched and gnt set on that edge.
REQ-020 Both req high in IDLE -> grant the requester not granted last (round-robin pointer); single req -> grant it.
REQ-021 ISSUE: calc_go=1 for exactly one cycle, calc_op/a/b driven from latches -> WAIT.
REQ-022 calc_op/calc_a/calc_b SHALL hold latched values from ISSUE through RESP.
REQ-023 WAIT: calc_done=1 -> capture calc_result -> RESP; calc_done ignored in every other state.
REQ-024 RESP: ack of owner=1 one cycle, result=captured value, then gnt cleared and -> IDLE; pointer updated to owner.
REQ-025 Minimum latency req->ack = 3 cycles + calculator latency; back-to-back grants separated by at least one IDLE cycle.
REQ-026 req sampled only in IDLE; req dropped after grant SHALL NOT abort the transaction; ack still issued.
REQ-027 Non-owning req held during a transaction stays pending and wins the next IDLE arbitration.
REQ-028 result and err SHALL be 0 whenever no ack is high.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, all outputs 0, latches 0, pointer = requester 1 (requester 0 wins first tie).
REQ-030 Reset mid-transaction SHALL drop the transaction with no ack; a calc_done arriving after reset release is ignored.

Configuration
REQ-031 Macro CALC_ARB_TIMEOUT_EN defined: WAIT counts cycles; count reaching TIMEOUT without calc_done -> RESP with result=0, err=1.
REQ-032 Macro undefined: WAIT persists until calc_done; no counter instantiated; err tied 0.

Structure
REQ-033 Shared package calc_pkg SHALL hold opcode constants (ADD, SUB, AND, XOR) and arbiter state encoding.
REQ-034 Timeout counter SHALL be sub-module calc_arb_timer (clear, enable, expired), instantiated only under CALC_ARB_TIMEOUT_EN.

Verification
REQ-035 req0 only, op0=11, a0=3, b0=4, calc_done 2 cycles after calc_go with calc_result=7 -> one calc_go, ack0 with result=7, err=0.
REQ-036 req0 and req1 high same cycle after reset -> gnt0 first, then gnt1; third tie -> gnt0.
REQ-037 req1 raised while requester 0 in WAIT -> no second calc_go until ack0, then gnt1 after one IDLE cycle.
REQ-038 rst=0 asserted in WAIT -> all outputs 0 same cycle; late calc_done -> no ack.
REQ-039 CALC_ARB_TIMEOUT_EN, TIMEOUT=15, calc_done never asserted -> ack after 15 WAIT cycles with err=1, result=0.
REQ-040 req0 dropped during WAIT, op0=10, a0=9, b0=2, calc_result=7 -> ack0 still pulsed with result=7.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode constants and arbiter state encoding
// for the two-requester calculator arbiter.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b11;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b00;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/calc_arb_timer.sv
// calc_arb_timer: counts WAIT cycles and flags the cycle on which
// the calculator has been waited on for TIMEOUT cycles.
module calc_arb_timer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == LAST);

  // cycle counter, restarts whenever the arbiter is not waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin arbiter granting one of two requesters a
// shared calculator. Optional WAIT timeout under CALC_ARB_TIMEOUT_EN.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int DW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] result,
  output logic          err,
  output logic          calc_go,
  output logic [1:0]    calc_op,
  output logic [DW-1:0] calc_a,
  output logic [DW-1:0] calc_b,
  input  logic          calc_done,
  input  logic [DW-1:0] calc_result,
  output logic          busy
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("calc_arbiter: TIMEOUT out of range 1..255");
  end

  arb_state_t r_state;
  arb_state_t w_next;

  logic          r_owner;
  logic          r_ptr;
  logic [1:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_res;

  logic w_any;
  logic w_win;
  logic w_wait;
  logic w_resp;
  logic w_tmo;

  assign w_any  = req0 | req1;
  // pointer holds the last owner; a tie goes to the other one
  assign w_win  = (req0 & req1) ? ~r_ptr : req1;
  assign w_wait = (r_state == ST_WAIT);
  assign w_resp = (r_state == ST_RESP);

`ifdef CALC_ARB_TIMEOUT_EN
  logic r_err;
  logic w_clr;

  assign w_clr = ~w_wait;

  calc_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clr),
    .i_enable  (w_wait),
    .o_expired (w_tmo)
  );

  // error flag: set on timeout, cleared on a real completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_wait) begin
      r_err <= ~calc_done & w_tmo;
    end
  end

  assign err = w_resp & r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (calc_done || w_tmo) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // owner/operand latches, result capture and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= 1'b0;
      r_ptr   <= 1'b1;
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_owner <= w_win;
        r_op    <= w_win ? op1 : op0;
        r_a     <= w_win ? a1 : a0;
        r_b     <= w_win ? b1 : b0;
      end
      if (w_wait) begin
        if (calc_done) begin
          r_res <= calc_result;
        end else if (w_tmo) begin
          r_res <= '0;
        end
      end
      if (w_resp) begin
        r_ptr <= r_owner;
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign gnt0    = busy & ~r_owner;
  assign gnt1    = busy & r_owner;
  assign ack0    = w_resp & ~r_owner;
  assign ack1    = w_resp & r_owner;
  assign result  = w_resp ? r_res : '0;
  assign calc_go = (r_state == ST_ISSUE);
  assign calc_op = r_op;
  assign calc_a  = r_a;
  assign calc_b  = r_b;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: scoreboard bench with a behavioural calculator;
// timeout scenario runs only when CALC_ARB_TIMEOUT_EN is defined.
module tb_calc_arbiter;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [1:0]    op0, op1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] result;
  logic          err;
  logic          calc_go;
  logic [1:0]    calc_op;
  logic [DW-1:0] calc_a, calc_b;
  logic          calc_done;
  logic [DW-1:0] calc_result;
  logic          busy;

  calc_arbiter #(.DW(DW), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .op0         (op0),
    .op1         (op1),
    .a0          (a0),
    .b0          (b0),
    .a1          (a1),
    .b1          (b1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .ack0        (ack0),
    .ack1        (ack1),
    .result      (result),
    .err         (err),
    .calc_go     (calc_go),
    .calc_op     (calc_op),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_done   (calc_done),
    .calc_result (calc_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [DW-1:0] res;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   go_cnt = 0;
  int   cal_lat = 2;
  bit   cal_en  = 1'b1;
  logic prev_go = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu(input logic [1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      2'b11:   return a + b;
      2'b10:   return a - b;
      2'b01:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic push(input int who, input logic [DW-1:0] res,
                      input logic e);
    exp_t x;
    x.who = who;
    x.res = res;
    x.err = e;
    q.push_back(x);
  endtask

  task automatic raise(input int who, input logic [1:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk);
    #1;
    if (who == 0) begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
  endtask

  task automatic wait_ack(input int who, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((who == 0) ? ack0 : ack1) found = 1'b1;
    end
    if (!found) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (who == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // behavioural calculator
  initial begin
    calc_done = 1'b0;
    calc_result = '0;
    forever begin
      @(negedge clk);
      if (calc_go) begin
        go_cnt++;
        if (cal_en) begin
          repeat (cal_lat) @(posedge clk);
          #1;
          calc_done = 1'b1;
          calc_result = alu(calc_op, calc_a, calc_b);
          @(posedge clk);
          #1;
          calc_done = 1'b0;
          calc_result = '0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
      if (calc_go) check("go_1cyc", {31'd0, prev_go}, 32'd0);
      prev_go = calc_go;
      if (ack0 || ack1) begin
        check("ack_both", {31'd0, ack0 & ack1}, 32'd0);
        if (q.size() == 0) begin
          check("unexp_ack", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("ack_who", {31'd0, ack1}, e.who);
          check("ack_gnt", {30'd0, gnt1, gnt0},
                (e.who == 1) ? 32'd2 : 32'd1);
          check("ack_res", {28'd0, result}, {28'd0, e.res});
          check("ack_err", {31'd0, err}, {31'd0, e.err});
        end
      end else begin
        check("noack_zero", {27'd0, err, result}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {11'd0, gnt0, gnt1, ack0, ack1, result, err,
            calc_go, calc_op, calc_a, calc_b, busy};
  endfunction

  initial begin
    int c;
    int g;
    logic [1:0] rop;
    logic [DW-1:0] ra, rb;
    int rw;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // single request, ADD 3+4, calculator latency 2
    cal_lat = 2;
    g = go_cnt;
    raise(0, 2'b11, 4'd3, 4'd4);
    push(0, 4'd7, 1'b0);
    wait_ack(0, c);
    check("lat_add", c, 32'd5);
    check("go_once", go_cnt - g, 32'd1);

    // request dropped while waiting, SUB 9-2
    cal_lat = 3;
    raise(0, 2'b10, 4'd9, 4'd2);
    push(0, 4'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("in_wait", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    wait_ack(0, c);

    // reset in WAIT, late calc_done must not ack
    cal_lat = 6;
    raise(0, 2'b11, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    g = go_cnt;
    #2 rst = 1'b0;
    #1;
    check("rst_async", all_outs(), 32'd0);
    req0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_idle", {31'd0, busy}, 32'd0);
    check("rst_nogo", go_cnt - g, 32'd0);

    // ties after reset: 0, then 1, then 0 again
    cal_lat = 1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      req0 = 1'b1; op0 = (k == 0) ? 2'b11 : 2'b00;
      a0 = (k == 0) ? 4'd5 : 4'hF; b0 = (k == 0) ? 4'd6 : 4'h3;
      req1 = 1'b1; op1 = (k == 0) ? 2'b01 : 2'b10;
      a1 = (k == 0) ? 4'hC : 4'd2; b1 = (k == 0) ? 4'hA : 4'd5;
      push(0, (k == 0) ? 4'hB : 4'hC, 1'b0);
      push(1, (k == 0) ? 4'h8 : 4'hD, 1'b0);
      wait_ack(0, c);
      wait_ack(1, c);
    end

    // req1 arrives while requester 0 waits
    cal_lat = 3;
    raise(0, 2'b11, 4'd7, 4'd8);
    push(0, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    g = go_cnt;
    req1 = 1'b1; op1 = 2'b01; a1 = 4'd6; b1 = 4'd3;
    push(1, 4'd2, 1'b0);
    wait_ack(0, c);
    check("pend_nogo", go_cnt - g, 32'd0);
    @(negedge clk);
    check("pend_idle", {30'd0, busy, gnt1}, 32'd0);
    @(negedge clk);
    check("pend_gnt1", {30'd0, gnt1, calc_go}, 32'd3);
    wait_ack(1, c);

    // randomised single transactions
    for (int k = 0; k < 8; k++) begin
      rw = $urandom_range(0, 1);
      rop = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      cal_lat = $urandom_range(1, 4);
      raise(rw, rop, ra, rb);
      push(rw, alu(rop, ra, rb), 1'b0);
      wait_ack(rw, c);
      check("rnd_lat", c, 32'(3 + cal_lat));
    end

`ifdef CALC_ARB_TIMEOUT_EN
    // calculator never answers
    cal_en = 1'b0;
    raise(0, 2'b11, 4'd1, 4'd1);
    push(0, 4'd0, 1'b1);
    wait_ack(0, c);
    check("lat_tmo", c, 32'd18);
    cal_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("q_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
